// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-clock frame, ack capture.
// Optional PS2_HOST_TX_RETRY_EN: one automatic retransmission after a NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_FRAME     = 3'd2;
    localparam logic [2:0] S_ACK       = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       k;
    logic [7:0]       byte_q;
    logic             parity_q;
    logic             nack_q;

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fall;

    logic busy_wait;
    logic idle_ok;
    logic timed_out;
    logic end_txn;
    logic end_err;
    logic retry_now;

`ifdef PS2_HOST_TX_RETRY_EN
    logic retried;
`endif

    // Both pins idle high on an open-drain bus, so the synchronizers reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    assign busy_wait = (state == S_FRAME) || (state == S_ACK) || (state == S_WAIT_IDLE);
    assign idle_ok   = (state == S_WAIT_IDLE) && clk_s2 && data_s2;
    assign timed_out = busy_wait && !fall && !idle_ok && (cnt == TO_LAST);
    assign end_txn   = idle_ok || timed_out;
    assign end_err   = timed_out || nack_q;

`ifdef PS2_HOST_TX_RETRY_EN
    assign retry_now = end_err && !retried;
`else
    assign retry_now = 1'b0;
`endif

    // Done pulse must not coincide with a new accept, so ready waits one cycle.
    assign tx_ready = (state == S_IDLE) && !tx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            k           <= 4'd0;
            byte_q      <= 8'h00;
            parity_q    <= 1'b0;
            nack_q      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        byte_q     <= tx_data;
                        parity_q   <= ~^tx_data;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                        retried    <= 1'b0;
`endif
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        k           <= 4'd0;
                        cnt         <= '0;
                        state       <= S_FRAME;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == INH_START)
                            ps2_data_oe <= 1'b1;
                    end
                end
                // Each detected fall sets up the bit the device samples on its next rising edge.
                S_FRAME: begin
                    if (fall) begin
                        cnt <= '0;
                        k   <= k + 4'd1;
                        if (k < 4'd8) begin
                            ps2_data_oe <= ~byte_q[k[2:0]];
                        end else if (k == 4'd8) begin
                            ps2_data_oe <= ~parity_q;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state       <= S_ACK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        nack_q <= data_s2;
                        cnt    <= '0;
                        state  <= S_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (fall)
                        cnt <= '0;
                    else
                        cnt <= cnt + CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase

            // Completion and timeout override whatever the state branch scheduled.
            if (end_txn) begin
                if (retry_now) begin
                    cnt         <= '0;
                    ps2_clk_oe  <= 1'b1;
                    ps2_data_oe <= 1'b0;
                    state       <= S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retried     <= 1'b1;
`endif
                end else begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_done     <= 1'b1;
                    tx_err      <= end_err;
                    state       <= S_IDLE;
                end
            end
        end
    end

endmodule
